// File: rtl/ahblite_simple_master_if.sv
// Request/response handshake plus AHB-Lite master signals for ahblite_simple_master.
// master modport is the bus master's view; slave modport is the requester/interconnect side.
interface ahblite_simple_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    output req_ready,
    output rsp_valid, rsp_err, rsp_rdata,
    output HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_err, rsp_rdata,
    input  HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahblite_simple_master.sv
// Single-outstanding AHB-Lite SINGLE-transfer master; 3 cycles accept-to-response at zero wait.
// Backpressure: req_ready only in IDLE; slave wait states stretch ADDR/DATA/ERR; rsp has none.
module ahblite_simple_master #(
  parameter logic [3:0] PROT = 4'b0011
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahblite_simple_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t      state_q, state_d;

  logic        wr_q,      wr_d;
  logic [1:0]  size_q,    size_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q,   wdata_d;

  logic [1:0]  htrans_q,  htrans_d;
  logic [31:0] haddr_q,   haddr_d;
  logic [2:0]  hsize_q,   hsize_d;
  logic        hwrite_q,  hwrite_d;
  logic [31:0] hwdata_q,  hwdata_d;
  logic [3:0]  hprot_q;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = lo[0];
      2'd2:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] lo,
                                          input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'd0: begin
        case (lo)
          2'd0:    r = {24'b0, d[7:0]};
          2'd1:    r = {24'b0, d[15:8]};
          2'd2:    r = {24'b0, d[23:16]};
          default: r = {24'b0, d[31:24]};
        endcase
      end
      2'd1:    r = lo[1] ? {16'b0, d[31:16]} : {16'b0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_lo_q   <= 2'b00;
      wdata_q     <= 32'b0;
      htrans_q    <= TRANS_IDLE;
      haddr_q     <= 32'b0;
      hsize_q     <= 3'b000;
      hwrite_q    <= 1'b0;
      hwdata_q    <= 32'b0;
      hprot_q     <= PROT;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      hprot_q     <= PROT;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    wdata_d     = wdata_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          // Illegal/misaligned requests never reach the bus; they complete with an error next cycle.
          if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = ST_ADDR;
            wr_d      = bus.req_write;
            size_d    = bus.req_size;
            addr_lo_d = bus.req_addr[1:0];
            wdata_d   = bus.req_wdata;
            htrans_d  = TRANS_NONSEQ;
            haddr_d   = bus.req_addr;
            hsize_d   = {1'b0, bus.req_size};
            hwrite_d  = bus.req_write;
          end
        end
      end

      ST_ADDR: begin
        if (bus.HREADY) begin
          state_d  = ST_DATA;
          htrans_d = TRANS_IDLE;
          if (wr_q) begin
            hwdata_d = replicate(size_q, wdata_q);
          end
        end
      end

      ST_DATA: begin
        case ({bus.HREADY, bus.HRESP})
          2'b10: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = wr_q ? 32'b0 : extract(size_q, addr_lo_q, bus.HRDATA);
          end
          2'b01: state_d = ST_ERR;
          // A one-cycle ERROR is a slave protocol violation; still completes as an error.
          2'b11: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
          default: state_d = ST_DATA;
        endcase
      end

      ST_ERR: begin
        if (bus.HREADY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);

  assign bus.HTRANS    = htrans_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HWDATA    = hwdata_q;
  assign bus.HPROT     = hprot_q;
  assign bus.HBURST    = 3'b000;
  assign bus.HMASTLOCK = 1'b0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahblite_simple_master.sv
// Bench for ahblite_simple_master: directed cases then randomized transfers with a cycle-driven slave.
// Expected bus/response values come from address/size arithmetic, not from the RTL structure.
module tb_ahblite_simple_master;
  localparam logic [3:0] PROT = 4'b0011;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 HCLK = ~HCLK;

  ahblite_simple_master_if bus ();

  ahblite_simple_master #(.PROT(PROT)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  function automatic bit is_bad(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1) return (a % 2) != 0;
    if (s == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] s, input logic [31:0] w);
    if (s == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (s == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] s, input logic [31:0] a,
                                            input logic [31:0] hr);
    if (s == 2'd0) return (hr >> (8 * (a % 4))) & 32'hFF;
    if (s == 2'd1) return (hr >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    return hr;
  endfunction

  task automatic idle_check;
    check_val("idle_htrans", bus.HTRANS, 32'd0);
    check_val("idle_rsp_valid", bus.rsp_valid, 32'd0);
    check_val("idle_req_ready", bus.req_ready, 32'd1);
  endtask

  // err_mode: 0 = OKAY, 1 = two-cycle ERROR (ew extra held cycles), 2 = one-cycle ERROR.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wdata, input int aw, input int dw,
                      input int err_mode, input int ew, input logic [31:0] hr);
    logic [31:0] exp_rd;
    check_val("accept_req_ready", bus.req_ready, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_size  = 2'($urandom);
    bus.req_wdata = $urandom;

    if (is_bad(addr, size)) begin
      check_val("mis_htrans", bus.HTRANS, 32'd0);
      check_val("mis_rsp_valid", bus.rsp_valid, 32'd1);
      check_val("mis_rsp_err", bus.rsp_err, 32'd1);
      check_val("mis_rsp_rdata", bus.rsp_rdata, 32'd0);
      return;
    end

    check_val("addr_rsp_valid", bus.rsp_valid, 32'd0);
    check_val("addr_req_ready", bus.req_ready, 32'd0);
    check_val("addr_htrans", bus.HTRANS, 32'd2);
    check_val("addr_haddr", bus.HADDR, addr);
    check_val("addr_hsize", bus.HSIZE, {30'd0, size});
    check_val("addr_hwrite", bus.HWRITE, {31'd0, wr});
    check_val("addr_hprot", bus.HPROT, {28'd0, PROT});
    check_val("addr_hburst", bus.HBURST, 32'd0);
    check_val("addr_hmastlock", bus.HMASTLOCK, 32'd0);
    for (int i = 0; i < aw; i++) begin
      bus.HREADY = 1'b0;
      tick();
      check_val("addr_wait_htrans", bus.HTRANS, 32'd2);
      check_val("addr_wait_haddr", bus.HADDR, addr);
    end
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    tick();

    check_val("data_htrans", bus.HTRANS, 32'd0);
    check_val("data_rsp_valid", bus.rsp_valid, 32'd0);
    if (wr) check_val("data_hwdata", bus.HWDATA, exp_wdata(size, wdata));
    for (int i = 0; i < dw; i++) begin
      bus.HREADY = 1'b0;
      bus.HRESP  = 1'b0;
      tick();
      check_val("data_wait_htrans", bus.HTRANS, 32'd0);
      check_val("data_wait_rsp_valid", bus.rsp_valid, 32'd0);
      if (wr) check_val("data_wait_hwdata", bus.HWDATA, exp_wdata(size, wdata));
    end

    if (err_mode == 1) begin
      for (int i = 0; i <= ew; i++) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        tick();
        check_val("err_htrans", bus.HTRANS, 32'd0);
        check_val("err_rsp_valid", bus.rsp_valid, 32'd0);
      end
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b1;
    end else if (err_mode == 2) begin
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b1;
    end else begin
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = hr;
    end
    tick();

    exp_rd = (err_mode != 0 || wr) ? 32'd0 : exp_rdata(size, addr, hr);
    check_val("rsp_valid", bus.rsp_valid, 32'd1);
    check_val("rsp_err", bus.rsp_err, (err_mode != 0) ? 32'd1 : 32'd0);
    check_val("rsp_rdata", bus.rsp_rdata, exp_rd);
    check_val("rsp_htrans", bus.HTRANS, 32'd0);
    check_val("rsp_req_ready", bus.req_ready, 32'd1);
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = $urandom;
  endtask

  task automatic reset_mid_data;
    check_val("rst_pre_req_ready", bus.req_ready, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h4000_0100;
    bus.req_size  = 2'd2;
    bus.req_wdata = 32'hCAFE_F00D;
    tick();
    bus.req_valid = 1'b0;
    bus.HREADY    = 1'b1;
    tick();
    bus.HREADY = 1'b0;
    tick();
    check_val("rst_in_data_hwdata", bus.HWDATA, 32'hCAFE_F00D);
    HRESETn = 1'b0;
    #1;
    check_val("rst_htrans", bus.HTRANS, 32'd0);
    check_val("rst_req_ready", bus.req_ready, 32'd1);
    check_val("rst_rsp_valid", bus.rsp_valid, 32'd0);
    check_val("rst_haddr", bus.HADDR, 32'd0);
    check_val("rst_hwdata", bus.HWDATA, 32'd0);
    check_val("rst_hwrite", bus.HWRITE, 32'd0);
    check_val("rst_hprot", bus.HPROT, {28'd0, PROT});
    @(negedge HCLK);
    HRESETn    = 1'b1;
    bus.HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_check();
    end
  endtask

  initial begin
    HRESETn       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_size  = 2'd0;
    bus.req_wdata = 32'd0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = 32'd0;
    repeat (2) @(negedge HCLK);

    check_val("reset_htrans", bus.HTRANS, 32'd0);
    check_val("reset_haddr", bus.HADDR, 32'd0);
    check_val("reset_hsize", bus.HSIZE, 32'd0);
    check_val("reset_hwrite", bus.HWRITE, 32'd0);
    check_val("reset_hwdata", bus.HWDATA, 32'd0);
    check_val("reset_hprot", bus.HPROT, {28'd0, PROT});
    check_val("reset_rsp_valid", bus.rsp_valid, 32'd0);
    check_val("reset_rsp_err", bus.rsp_err, 32'd0);
    check_val("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check_val("reset_req_ready", bus.req_ready, 32'd1);
    HRESETn = 1'b1;
    tick();
    idle_check();

    xfer(1'b1, 32'h4000_0010, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'd0);
    tick();
    idle_check();
    xfer(1'b0, 32'h4000_0003, 2'd0, 32'd0, 0, 2, 0, 0, 32'h1122_3344);
    check_val("byte_read_value", bus.rsp_rdata, 32'h0000_0011);
    tick();
    xfer(1'b1, 32'h4000_0002, 2'd1, 32'h0000_ABCD, 0, 0, 0, 0, 32'd0);
    tick();
    xfer(1'b0, 32'h4000_0020, 2'd2, 32'd0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    tick();
    xfer(1'b0, 32'h4000_0006, 2'd2, 32'd0, 0, 0, 0, 0, 32'd0);
    tick();
    idle_check();
    xfer(1'b0, 32'h4000_0004, 2'd2, 32'd0, 1, 0, 0, 0, 32'h8765_4321);
    xfer(1'b0, 32'h4000_0006, 2'd1, 32'd0, 0, 0, 0, 0, 32'hBEEF_1234);
    xfer(1'b1, 32'h4000_0008, 2'd2, 32'h1234_5678, 0, 1, 2, 0, 32'd0);
    xfer(1'b0, 32'h4000_0001, 2'd3, 32'd0, 0, 0, 0, 0, 32'd0);
    tick();
    reset_mid_data();

    for (int n = 0; n < 300; n++) begin
      int gap, aw, dw, em, ew, r;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        idle_check();
      end
      aw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      ew = $urandom_range(0, 1);
      r  = $urandom_range(0, 19);
      em = (r < 2) ? 1 : ((r == 2) ? 2 : 0);
      xfer(1'($urandom), $urandom, 2'($urandom), $urandom, aw, dw, em, ew, $urandom);
    end
    tick();
    idle_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ahblite_simple_master.md
# ahblite_simple_master

Single-outstanding AHB-Lite bus master. It turns one-at-a-time read/write requests from a local requester (DMA engine, debug bridge or test sequencer) into AHB-Lite SINGLE transfers toward the interconnect and its slaves, such as the GPIO and timer peripherals. It handles slave wait states and two-cycle ERROR responses. It does byte-lane replication on writes and lane extraction on reads, so requesters always work with LSB-aligned data.

## Interface
- `PROT`, default 4'b0011, value driven on HPROT for every transfer (non-cacheable, non-bufferable, privileged data).
- `HCLK`  in  1  bus clock; all logic is on the rising edge.
- `HRESETn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on an edge where `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  transfer size: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `req_wdata`  in  32  write data, LSB-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_err`  out  1  completion was an error; qualified by `rsp_valid`.
- `rsp_rdata`  out  32  read data, LSB-aligned and zero-extended; 0 for writes and errors.
- `HADDR`  out  32, `HTRANS`  out  2, `HSIZE`  out  3, `HWRITE`  out  1, `HBURST`  out  3 (constant 3'b000), `HPROT`  out  4, `HMASTLOCK`  out  1 (constant 0), `HWDATA`  out  32.
- `HREADY`  in  1, `HRDATA`  in  32, `HRESP`  in  1.

## Operation
- The FSM has four states: IDLE, ADDR, DATA and ERR. `req_ready = (state == IDLE)`.
- **IDLE:** HTRANS = 2'b00. On accept:
  - An aligned request is latched and the FSM goes to ADDR.
  - A misaligned or illegal request goes nowhere on the bus. It stays in IDLE and pulses `rsp_valid`/`rsp_err=1` on the next cycle. Misaligned means halfword with addr[0]=1, word with addr[1:0]≠0, or size 3.
- **ADDR:** HTRANS = 2'b10 (NONSEQ); HADDR, HSIZE = {1'b0, size}, HWRITE and HPROT are driven from the latched request. The FSM holds in ADDR until HREADY=1 is sampled, then goes to DATA.
- **DATA:** HTRANS = IDLE. HWDATA holds the replicated write data for the whole phase: byte → {4{b}}, halfword → {2{h}}, word unchanged. Exit depends on what is sampled:
  - HREADY=1 & HRESP=0: capture HRDATA, go to IDLE, pulse `rsp_valid` with `rsp_err=0`.
  - HREADY=0 & HRESP=1: first ERROR cycle; go to ERR.
  - HREADY=1 & HRESP=1: protocol violation; treated as an error completion.
  - HREADY=0 & HRESP=0: stay in DATA.
- **ERR:** HTRANS is held IDLE (no transfer is ever issued or cancelled here). When HREADY=1 is sampled, go to IDLE and pulse `rsp_valid` with `rsp_err=1`.
- **Read extraction:**
  - Byte: `rsp_rdata = {24'b0, HRDATA[8*a+7 : 8*a]}`, with a = addr[1:0].
  - Halfword: `rsp_rdata = {16'b0, HRDATA[16*addr[1]+15 : 16*addr[1]]}`.
  - Word: HRDATA unchanged.
- Request fields are sampled only on the accept edge; changes to `req_*` afterwards have no effect.
- Reset mid-transfer: the FSM returns to IDLE immediately and all outputs take their reset values. The in-flight request is dropped with no response.

## Timing
- All bus outputs, `rsp_*` and `HWDATA` are registered; `req_ready` is decoded from state.
- Reset values:
  - HTRANS = 00, HADDR = 0, HSIZE = 0, HWRITE = 0, HWDATA = 0, HPROT = PROT.
  - `rsp_valid = 0`, `rsp_err = 0`, `rsp_rdata = 0`.
  - `req_ready = 1` (state is IDLE).
- Zero-wait latency, with the accept at edge E0:
  - NONSEQ is on the bus in cycle E0→E1.
  - The data phase is in E1→E2.
  - `rsp_valid` is high in E2→E3.
  - Total: 3 cycles accept-to-response. Each wait state in ADDR or DATA adds 1 cycle; an error response adds at least 1.
- `req_ready` is high in the same cycle as `rsp_valid`, so the next accept can occur there. Peak rate is one transfer per 3 cycles.
- The misaligned-request response arrives 1 cycle after accept.
- `rsp_valid` is high for exactly one cycle per accepted request. The exception is reset mid-transfer, which produces no response.

## Test plan
- **Word write, zero wait:** `req_addr` = 0x4000_0010, wdata = 0xDEAD_BEEF → HTRANS = 10 one cycle with HADDR = 0x4000_0010, HSIZE = 010, HWRITE = 1; HWDATA = 0xDEAD_BEEF next cycle; `rsp_valid` 3 cycles after accept with `rsp_err` = 0.
- **Byte read, 2 wait states:** addr = 0x...03, slave holds HREADY low 2 cycles, HRDATA = 0x1122_3344 → `rsp_rdata` = 0x0000_0011; `rsp_valid` 5 cycles after accept.
- **Halfword write:** addr = 0x...02, wdata = 0x0000_ABCD → HWDATA = 0xABCD_ABCD, HSIZE = 001.
- **Slave error:** DATA phase gets HRESP = 1 / HREADY = 0, then HRESP = 1 / HREADY = 1 → HTRANS stays 00 throughout; `rsp_valid` with `rsp_err` = 1 and `rsp_rdata` = 0.
- **Misaligned request:** word at 0x...06 → no NONSEQ on the bus; `rsp_err` = 1 one cycle after accept.
- **Back-to-back and reset:**
  - Second request presented while the first response pulses → it is accepted in that cycle.
  - HRESETn asserted during DATA → HTRANS = 00 and `req_ready` = 1 immediately, and no `rsp_valid` follows.
